// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate L1 data cache
// controller that sits between the MEM stage and data memory.
//
// The controller owns the tag, valid, dirty and data arrays. When an access
// misses, it raises the pipeline hold. While the hold is high, it writes back
// a dirty victim line, waits one idle cycle, and then refills the line over the
// 256-bit memory handshake.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   cpu_addr_i            byte address from the EXMEM ALU result
//   cpu_data_i            store data
//   cpu_MemRead_i         load request
//   cpu_MemWrite_i        store request (takes priority when both are set)
//   cpu_data_o            load data, combinational, zero when the access does not hit
//   Miss_stall_o          pipeline hold, combinational: req & ~hit
//   mem_data_i, mem_ack_i refill block and one-cycle completion pulse from memory
//   mem_data_o            victim block for writeback
//   mem_addr_o            block-aligned memory address
//   mem_enable_o          memory request level
//   mem_write_o           1 = writeback, 0 = refill read
module dcache_controller (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    input  logic         cpu_MemRead_i,
    input  logic         cpu_MemWrite_i,
    output logic [31:0]  cpu_data_o,
    output logic         Miss_stall_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
    output logic [255:0] mem_data_o,
    output logic [31:0]  mem_addr_o,
    output logic         mem_enable_o,
    output logic         mem_write_o
);

    localparam int unsigned NUM_LINES  = 16;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned OFF_W      = 5;
    localparam int unsigned BLOCK_BITS = 256;
    localparam int unsigned TAG_W      = 32 - IDX_W - OFF_W;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITEBACK = 3'd1,
        GAP       = 3'd2,
        ALLOCATE  = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t                state_q, state_d;

    logic [TAG_W-1:0]      tag_q   [NUM_LINES];
    logic [BLOCK_BITS-1:0] data_q  [NUM_LINES];
    logic [NUM_LINES-1:0]  valid_q;
    logic [NUM_LINES-1:0]  dirty_q;

    logic [IDX_W-1:0]      idx;
    logic [2:0]            word;
    logic [TAG_W-1:0]      tag;
    logic                  req;
    logic                  hit;
    logic                  store_hit;
    logic                  fill;
    logic [BLOCK_BITS-1:0] cur_line;
    logic                  unused_byte_bits;

    logic                  en_d;
    logic                  wr_d;
    logic [31:0]           addr_d;
    logic [BLOCK_BITS-1:0] data_d;

    // Address decode and hit detection
    assign idx              = cpu_addr_i[8:5];
    assign word             = cpu_addr_i[4:2];
    assign tag              = cpu_addr_i[31:9];
    assign unused_byte_bits = ^cpu_addr_i[1:0];
    assign req              = cpu_MemRead_i | cpu_MemWrite_i;
    assign hit              = valid_q[idx] & (tag_q[idx] == tag);
    assign store_hit        = cpu_MemWrite_i & hit;
    assign cur_line         = data_q[idx];

    assign Miss_stall_o = req & ~hit;
    assign cpu_data_o   = hit ? cur_line[{word, 5'd0} +: 32] : 32'd0;

    // Refill lands on the ack cycle of ALLOCATE
    assign fill = (state_q == ALLOCATE) & mem_ack_i;

    // State register and registered memory-interface outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= 32'd0;
            mem_data_o   <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_o <= en_d;
            mem_write_o  <= wr_d;
            mem_addr_o   <= addr_d;
            mem_data_o   <= data_d;
        end
    end

    // Next-state logic and next memory-interface values
    always_comb begin
        state_d = state_q;
        en_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = mem_addr_o;
        data_d  = mem_data_o;
        unique case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    if (valid_q[idx] && dirty_q[idx]) begin
                        state_d = WRITEBACK;
                        en_d    = 1'b1;
                        wr_d    = 1'b1;
                        addr_d  = {tag_q[idx], idx, 5'd0};
                        data_d  = cur_line;
                    end else begin
                        state_d = ALLOCATE;
                        en_d    = 1'b1;
                        addr_d  = {tag, idx, 5'd0};
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d = GAP;
                end else begin
                    en_d = 1'b1;
                    wr_d = 1'b1;
                end
            end
            GAP: begin
                state_d = ALLOCATE;
                en_d    = 1'b1;
                addr_d  = {tag, idx, 5'd0};
            end
            ALLOCATE: begin
                if (mem_ack_i) begin
                    state_d = DONE;
                end else begin
                    en_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Valid/dirty bookkeeping; a store hit (including the merge in DONE) dirties the line
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (store_hit) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data arrays; contents are meaningless until the valid bit is set
    always_ff @(posedge clk_i) begin
        if (fill) begin
            data_q[idx] <= mem_data_i;
            tag_q[idx]  <= tag;
        end else if (store_hit) begin
            data_q[idx][{word, 5'd0} +: 32] <= cpu_data_i;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: cold refill, store/load hits, dirty
// writeback with its gap cycle, store-miss merge, asynchronous reset while a
// refill is in progress, and a stray memory ack while the cache is idle.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         Miss_stall_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [255:0] mem_data_o;
    logic [31:0]  mem_addr_o;
    logic         mem_enable_o;
    logic         mem_write_o;

    int vectors     = 0;
    int miscompares = 0;

    dcache_controller dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_data_o     (cpu_data_o),
        .Miss_stall_o   (Miss_stall_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i),
        .mem_data_o     (mem_data_o),
        .mem_addr_o     (mem_addr_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o)
    );

    always #5 clk_i = ~clk_i;

    // Read and write are never requested together
    always @(negedge clk_i) begin
        assert (!(cpu_MemRead_i && cpu_MemWrite_i))
            else $error("FAIL illegal_rd_wr observed=1 expected=0");
    end

    task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp)
            else begin
                miscompares++;
                $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
            end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n_i        = 1'b0;
        cpu_addr_i     = 32'd0;
        cpu_data_i     = 32'd0;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
        mem_data_i     = '0;
        mem_ack_i      = 1'b0;
        step();
        step();
        chk("rst_enable", 256'(mem_enable_o), 256'd0);
        chk("rst_write",  256'(mem_write_o),  256'd0);
        chk("rst_addr",   256'(mem_addr_o),   256'd0);
        chk("rst_data",   mem_data_o,         256'd0);
        chk("rst_stall",  256'(Miss_stall_o), 256'd0);
        rst_n_i = 1'b1;
        step();

        // 1. Cold load 0x100
        cpu_MemRead_i = 1'b1;
        cpu_addr_i    = 32'h100;
        settle();
        chk("t1_stall_same_cycle", 256'(Miss_stall_o), 256'd1);
        chk("t1_data_on_miss",     256'(cpu_data_o),   256'd0);
        step();
        chk("t1_alloc_enable", 256'(mem_enable_o), 256'd1);
        chk("t1_alloc_write",  256'(mem_write_o),  256'd0);
        chk("t1_alloc_addr",   256'(mem_addr_o),   256'h100);
        for (int i = 0; i < 9; i++) begin
            step();
            chk("t1_stall_wait",  256'(Miss_stall_o), 256'd1);
            chk("t1_enable_wait", 256'(mem_enable_o), 256'd1);
        end
        mem_data_i = 256'hA1A1A1A1_DEADBEEF;
        mem_ack_i  = 1'b1;
        step();
        mem_ack_i = 1'b0;
        chk("t1_done_stall",  256'(Miss_stall_o), 256'd0);
        chk("t1_done_data",   256'(cpu_data_o),   256'hDEADBEEF);
        chk("t1_done_enable", 256'(mem_enable_o), 256'd0);
        step();

        // 2. Store hit 0x104 then load it back
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b1;
        cpu_addr_i     = 32'h104;
        cpu_data_i     = 32'h12345678;
        settle();
        chk("t2_store_hit_stall", 256'(Miss_stall_o), 256'd0);
        step();
        cpu_MemWrite_i = 1'b0;
        cpu_MemRead_i  = 1'b1;
        settle();
        chk("t2_load_stall", 256'(Miss_stall_o), 256'd0);
        chk("t2_load_data",  256'(cpu_data_o),   256'h12345678);
        cpu_addr_i = 32'h100;
        settle();
        chk("t2_word0_kept", 256'(cpu_data_o), 256'hDEADBEEF);
        step();

        // 3. Load 0x300 evicts the dirty 0x100 line
        cpu_addr_i = 32'h300;
        settle();
        chk("t3_stall", 256'(Miss_stall_o), 256'd1);
        step();
        chk("t3_wb_enable", 256'(mem_enable_o), 256'd1);
        chk("t3_wb_write",  256'(mem_write_o),  256'd1);
        chk("t3_wb_addr",   256'(mem_addr_o),   256'h100);
        chk("t3_wb_data",   mem_data_o,         256'hA1A1A1A1_12345678_DEADBEEF & {192'd0, 64'hFFFFFFFF_FFFFFFFF});
        step();
        step();
        chk("t3_wb_addr_stable", 256'(mem_addr_o),  256'h100);
        chk("t3_wb_word1_stable", 256'(mem_data_o[63:32]), 256'h12345678);
        mem_ack_i = 1'b1;
        step();
        mem_ack_i = 1'b0;
        chk("t3_gap_enable", 256'(mem_enable_o), 256'd0);
        chk("t3_gap_stall",  256'(Miss_stall_o), 256'd1);
        step();
        chk("t3_alloc_enable", 256'(mem_enable_o), 256'd1);
        chk("t3_alloc_write",  256'(mem_write_o),  256'd0);
        chk("t3_alloc_addr",   256'(mem_addr_o),   256'h300);
        mem_data_i = 256'h0BADF00D_55AA55AA;
        mem_ack_i  = 1'b1;
        step();
        mem_ack_i = 1'b0;
        chk("t3_done_stall", 256'(Miss_stall_o), 256'd0);
        chk("t3_done_data",  256'(cpu_data_o),   256'h55AA55AA);
        step();
        cpu_MemRead_i = 1'b0;
        cpu_addr_i    = 32'h100;
        settle();
        cpu_MemRead_i = 1'b1;
        settle();
        chk("t3_old_line_gone", 256'(Miss_stall_o), 256'd1);
        cpu_MemRead_i = 1'b0;
        step();

        // 4. Store miss 0x520 into an empty line: no writeback, merge in DONE
        cpu_MemWrite_i = 1'b1;
        cpu_addr_i     = 32'h520;
        cpu_data_i     = 32'hCAFEF00D;
        settle();
        chk("t4_stall", 256'(Miss_stall_o), 256'd1);
        step();
        chk("t4_alloc_enable", 256'(mem_enable_o), 256'd1);
        chk("t4_alloc_write",  256'(mem_write_o),  256'd0);
        chk("t4_alloc_addr",   256'(mem_addr_o),   256'h520);
        mem_data_i = 256'h22222222_11111111;
        mem_ack_i  = 1'b1;
        step();
        mem_ack_i = 1'b0;
        chk("t4_done_stall", 256'(Miss_stall_o), 256'd0);
        step();
        cpu_MemWrite_i = 1'b0;
        cpu_MemRead_i  = 1'b1;
        settle();
        chk("t4_merged_word0", 256'(cpu_data_o), 256'hCAFEF00D);
        cpu_addr_i = 32'h524;
        settle();
        chk("t4_refill_word1", 256'(cpu_data_o), 256'h22222222);

        // Line 9 is now dirty: 0x720 must write it back first
        cpu_addr_i = 32'h720;
        step();
        chk("t4_wb_write", 256'(mem_write_o), 256'd1);
        chk("t4_wb_addr",  256'(mem_addr_o),  256'h520);
        chk("t4_wb_word0", 256'(mem_data_o[31:0]), 256'hCAFEF00D);
        mem_ack_i = 1'b1;
        step();
        mem_ack_i = 1'b0;
        step();
        chk("t5_alloc_enable", 256'(mem_enable_o), 256'd1);
        chk("t5_alloc_addr",   256'(mem_addr_o),   256'h720);

        // 5. Asynchronous reset mid-ALLOCATE
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("t5_async_enable", 256'(mem_enable_o), 256'd0);
        chk("t5_async_write",  256'(mem_write_o),  256'd0);
        chk("t5_async_addr",   256'(mem_addr_o),   256'd0);
        chk("t5_async_data",   mem_data_o,         256'd0);
        cpu_MemRead_i = 1'b0;
        step();
        step();
        rst_n_i = 1'b1;
        step();
        cpu_addr_i    = 32'h100;
        cpu_MemRead_i = 1'b1;
        settle();
        chk("t5_load_misses", 256'(Miss_stall_o), 256'd1);
        cpu_addr_i = 32'h300;
        settle();
        chk("t5_valid_cleared", 256'(Miss_stall_o), 256'd1);
        cpu_MemRead_i = 1'b0;
        settle();

        // 6. Stray ack while idle
        mem_ack_i = 1'b1;
        step();
        mem_ack_i = 1'b0;
        chk("t6_stall",  256'(Miss_stall_o), 256'd0);
        chk("t6_enable", 256'(mem_enable_o), 256'd0);
        step();
        chk("t6_enable_later", 256'(mem_enable_o), 256'd0);
        chk("t6_write_later",  256'(mem_write_o),  256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
